// File: rtl/axi4_s_bus_wr_engine.sv
// AXI4 slave write engine: pops AW/W FIFO pairs, drives a register
// write port with timeout, and pushes the write response to the B FIFO.
module axi4_s_bus_wr_engine #(
  parameter int unsigned     A_W     = 32,
  parameter int unsigned     D_W     = 32,
  parameter longint unsigned BASE    = 0,
  parameter longint unsigned SIZE    = 4096,
  parameter int unsigned     TIMEOUT = 255
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               aw_rd_empty,
  output logic               aw_rd_en,
  input  logic [A_W-1:0]     aw_rd_data,
  input  logic               w_rd_empty,
  output logic               w_rd_en,
  input  logic [D_W+D_W/8-1:0] w_rd_data,
  input  logic               b_wr_full,
  output logic               b_wr_en,
  output logic [1:0]         b_wr_data,
  output logic               reg_wr_en,
  output logic [A_W-1:0]     reg_addr,
  output logic [D_W-1:0]     reg_wdata,
  output logic [D_W/8-1:0]   reg_wstrb,
  input  logic               reg_ack,
  input  logic               reg_err,
  output logic               busy
);

  localparam int unsigned SW = D_W / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [64:0]    LO    = 65'(BASE);
  localparam logic [64:0]    WIN   = 65'(SIZE);
  localparam logic [A_W-1:0] AMASK = ~A_W'(SW - 1);
  localparam logic [15:0]    TMO   = 16'(TIMEOUT);

  logic [1:0]     r_state;
  logic [15:0]    r_cnt;
  logic           r_pop;
  logic           r_bvld;
  logic [1:0]     r_bresp;
  logic           r_wen;
  logic [A_W-1:0] r_addr;
  logic [D_W-1:0] r_wdata;
  logic [SW-1:0]  r_wstrb;

  logic           w_avail;
  logic [64:0]    w_off;
  logic           w_hit;
  logic           w_tmo;

  assign w_avail = !aw_rd_empty && !w_rd_empty;
  // Below-BASE addresses wrap to a huge offset, so one compare decodes
  assign w_off   = 65'(aw_rd_data) - LO;
  assign w_hit   = w_off < WIN;
  assign w_tmo   = (r_cnt + 16'd1) == TMO;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pop   <= 1'b0;
      r_bvld  <= 1'b0;
      r_bresp <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      r_pop <= 1'b0;
      unique case (1'b1)
        r_state == S_IDLE: begin
          if (r_pop) begin
            r_addr  <= aw_rd_data & AMASK;
            r_wdata <= w_rd_data[D_W-1:0];
            r_wstrb <= w_rd_data[D_W+SW-1:D_W];
            r_cnt   <= '0;
            if (w_hit) begin
              r_state <= S_WRITE;
              r_wen   <= 1'b1;
              r_bresp <= OKAY;
            end else begin
              r_state <= S_RESP;
              r_bresp <= DECERR;
              r_bvld  <= !b_wr_full;
            end
          end else begin
            r_pop <= w_avail;
          end
        end
        r_state == S_WRITE: begin
          if (reg_ack) begin
            r_state <= S_RESP;
            r_wen   <= 1'b0;
            r_bresp <= reg_err ? SLVERR : OKAY;
            r_bvld  <= !b_wr_full;
          end else if (w_tmo) begin
            r_state <= S_RESP;
            r_wen   <= 1'b0;
            r_bresp <= SLVERR;
            r_bvld  <= !b_wr_full;
            r_cnt   <= r_cnt + 16'd1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        r_state == S_RESP: begin
          // Push cycle: next pop may start as soon as we are back in IDLE
          if (r_bvld) begin
            r_state <= S_IDLE;
            r_bvld  <= 1'b0;
            r_pop   <= w_avail;
          end else begin
            r_bvld <= !b_wr_full;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wen   <= 1'b0;
          r_bvld  <= 1'b0;
        end
      endcase
    end
  end

  assign aw_rd_en  = r_pop;
  assign w_rd_en   = r_pop;
  assign b_wr_en   = r_bvld;
  assign b_wr_data = r_bresp;
  assign reg_wr_en = r_wen;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_wstrb = r_wstrb;
  assign busy      = r_state != S_IDLE;

endmodule

// File: tb/tb_axi4_s_bus_wr_engine.sv
// Scoreboard bench for axi4_s_bus_wr_engine: queue-modelled FIFOs,
// planned register-slave responses, expected B responses in order.
module tb_axi4_s_bus_wr_engine;

  localparam int TMO = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lat;
    bit          err;
  } txn_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        aw_rd_empty = 1'b1;
  logic        aw_rd_en;
  logic [31:0] aw_rd_data = '0;
  logic        w_rd_empty = 1'b1;
  logic        w_rd_en;
  logic [35:0] w_rd_data = '0;
  logic        b_wr_full = 1'b0;
  logic        b_wr_en;
  logic [1:0]  b_wr_data;
  logic        reg_wr_en;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ack = 1'b0;
  logic        reg_err = 1'b0;
  logic        busy;

  axi4_s_bus_wr_engine #(
    .A_W(32), .D_W(32), .BASE(0), .SIZE(4096), .TIMEOUT(TMO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .aw_rd_empty(aw_rd_empty), .aw_rd_en(aw_rd_en),
    .aw_rd_data(aw_rd_data),
    .w_rd_empty(w_rd_empty), .w_rd_en(w_rd_en),
    .w_rd_data(w_rd_data),
    .b_wr_full(b_wr_full), .b_wr_en(b_wr_en),
    .b_wr_data(b_wr_data),
    .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ack(reg_ack), .reg_err(reg_err),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int pops = 0;
  int unbal = 0;
  bit rand_full = 0;
  bit pop_d = 0;

  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [1:0]  exp_b[$];
  txn_t        plan[$];

  task automatic check(string nm, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return {aw_rd_en, w_rd_en, b_wr_en, b_wr_data, reg_wr_en,
            reg_addr, reg_wdata, reg_wstrb, busy};
  endfunction

  // Reference: in-window writes go to the slave; response from plan
  task automatic model(txn_t t);
    logic [1:0] br;
    if (t.addr < 32'h1000) begin
      plan.push_back(t);
      if (t.lat < TMO) br = t.err ? 2'b10 : 2'b00;
      else br = 2'b10;
    end else begin
      br = 2'b11;
    end
    exp_b.push_back(br);
  endtask

  task automatic issue(txn_t t);
    aw_q.push_back(t.addr);
    w_q.push_back({t.strb, t.data});
    model(t);
  endtask

  always @(posedge aclk) cyc++;

  // FIFO heads: the entry leaves after the edge that ends the pop cycle
  always @(negedge aclk) begin
    if (!aresetn) begin
      pop_d = 0;
    end else begin
      if (aw_rd_en !== w_rd_en) unbal++;
      if (pop_d) begin
        if (aw_q.size() == 0 || w_q.size() == 0) unbal++;
        else begin
          void'(aw_q.pop_front());
          void'(w_q.pop_front());
        end
      end
      pop_d = aw_rd_en;
      if (aw_rd_en) pops++;
    end
    aw_rd_empty = aw_q.size() == 0;
    aw_rd_data  = aw_rd_empty ? 32'h0 : aw_q[0];
    w_rd_empty  = w_q.size() == 0;
    w_rd_data   = w_rd_empty ? 36'h0 : w_q[0];
  end

  txn_t cur;
  bit   in_txn = 0;
  int   hi = 0;
  bit   stab = 1;

  always @(negedge aclk) begin
    if (!aresetn) begin
      in_txn = 0;
      reg_ack = 1'b0;
      reg_err = 1'b0;
    end else if (reg_wr_en) begin
      if (!in_txn) begin
        if (plan.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_reg_wr: addr %0h", reg_addr);
          cur.addr = reg_addr;
          cur.data = reg_wdata;
          cur.strb = reg_wstrb;
          cur.lat = TMO;
          cur.err = 0;
        end else begin
          cur = plan.pop_front();
          check("reg_addr", reg_addr, cur.addr & ~32'h3);
          check("reg_wdata", reg_wdata, cur.data);
          check("reg_wstrb", reg_wstrb, cur.strb);
        end
        in_txn = 1;
        hi = 0;
        stab = 1;
      end
      if (reg_addr !== (cur.addr & ~32'h3) ||
          reg_wdata !== cur.data || reg_wstrb !== cur.strb)
        stab = 0;
      hi++;
      reg_ack = (hi - 1 == cur.lat);
      reg_err = reg_ack ? cur.err : 1'($urandom);
    end else begin
      if (in_txn) begin
        check("reg_wr_len", hi, (cur.lat < TMO) ? cur.lat + 1 : TMO);
        check("reg_stable", stab, 1);
        in_txn = 0;
      end
      reg_ack = 1'($urandom);
      reg_err = 1'($urandom);
    end
  end

  always @(negedge aclk) begin
    if (aresetn && b_wr_en) begin
      check("b_push_not_full", b_wr_full, 0);
      if (exp_b.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_b_push: got %0h", b_wr_data);
      end else begin
        check("bresp", b_wr_data, exp_b.pop_front());
      end
    end
  end

  always @(negedge aclk)
    if (rand_full && !b_wr_en)
      b_wr_full = ($urandom_range(0, 3) == 0);

  task automatic wait_idle(int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk);
      #1;
      if (exp_b.size() == 0 && aw_q.size() == 0 &&
          w_q.size() == 0 && !busy && !aw_rd_en) begin
        ok = 1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL drain_timeout: %0d responses outstanding",
               exp_b.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t t;
    int pc, rc, bc, p0, cnt;

    repeat (3) @(negedge aclk);
    #1;
    check("reset_outs", outs(), 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Single write, latency from pop to B push
    t = '{addr: 32'h10, data: 32'hDEADBEEF, strb: 4'hF, lat: 0, err: 0};
    issue(t);
    pc = -1;
    rc = -1;
    bc = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge aclk);
      if (aw_rd_en && pc < 0) pc = cyc;
      if (reg_wr_en && rc < 0) rc = cyc;
      if (b_wr_en && bc < 0) bc = cyc;
    end
    check("lat_reg_wr", rc - pc, 1);
    check("lat_b_push", bc - pc, 2);
    wait_idle(50);

    // Decode miss
    t = '{addr: 32'h2000, data: 32'h1234, strb: 4'h3, lat: 0, err: 0};
    issue(t);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (reg_wr_en) cnt++;
    end
    check("miss_no_wr", cnt, 0);
    wait_idle(50);

    // Timeout
    t = '{addr: 32'h46, data: 32'hCAFE0001, strb: 4'h5, lat: 10, err: 0};
    issue(t);
    wait_idle(60);

    // Backpressure and ordering
    b_wr_full = 1'b1;
    p0 = pops;
    for (int i = 0; i < 3; i++) begin
      t.addr = 32'h100 + 32'(i * 4);
      t.data = $urandom;
      t.strb = 4'($urandom_range(0, 15));
      t.lat = $urandom_range(0, 2);
      t.err = 1'($urandom_range(0, 1));
      issue(t);
    end
    repeat (20) @(negedge aclk);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      #1;
      if (!busy) cnt++;
    end
    check("bp_busy_held", cnt, 0);
    check("bp_single_pop", pops - p0, 1);
    b_wr_full = 1'b0;
    wait_idle(200);
    check("bp_total_pops", pops - p0, 3);

    // AW present without W
    t = '{addr: 32'h80, data: 32'h55AA55AA, strb: 4'hC, lat: 1, err: 1};
    p0 = pops;
    aw_q.push_back(t.addr);
    repeat (20) @(negedge aclk);
    check("unbal_no_pop", pops - p0, 0);
    w_q.push_back({t.strb, t.data});
    model(t);
    wait_idle(60);
    check("unbal_one_pop", pops - p0, 1);

    // Reset during WRITE abandons the transaction
    t = '{addr: 32'h200, data: 32'h0BAD0BAD, strb: 4'hF, lat: 10, err: 0};
    issue(t);
    cnt = 0;
    while (!reg_wr_en && cnt < 40) begin
      @(negedge aclk);
      cnt++;
    end
    check("midrst_reached_write", reg_wr_en, 1);
    @(negedge aclk);
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_outs", outs(), 0);
    exp_b.delete();
    plan.delete();
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (b_wr_en || reg_wr_en || aw_rd_en) cnt++;
    end
    check("midrst_quiet", cnt, 0);

    // Randomized traffic with random B backpressure
    p0 = pops;
    rand_full = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        t.addr = 32'h1000 + $urandom_range(0, 32'h7FFF0000);
      else
        t.addr = $urandom_range(0, 4095);
      t.data = $urandom;
      t.strb = 4'($urandom_range(0, 15));
      t.lat = $urandom_range(0, 6);
      t.err = 1'($urandom_range(0, 1));
      issue(t);
      repeat ($urandom_range(0, 6)) @(negedge aclk);
    end
    wait_idle(3000);
    rand_full = 0;
    @(negedge aclk);
    b_wr_full = 1'b0;
    check("rand_pops", pops - p0, 40);
    check("aw_w_balanced", unbal, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi4_s_bus_wr_engine.md
AXI4_S_BUS_WR_ENGINE -- requirements
Module: axi4_s_bus_wr_engine

Interface
REQ-001 Parameter A_W, default 32: AW FIFO entry width (awaddr) and reg_addr width.
REQ-002 Parameter D_W, default 32: write data width; must be 32 or 64; strobe width is D_W/8.
REQ-003 Parameter BASE, default 0: first decoded byte address.
REQ-004 Parameter SIZE, default 4096: decoded window size in bytes, power of two.
REQ-005 Parameter TIMEOUT, default 255: maximum cycles to wait for reg_ack; range 1..65535.
REQ-006 aclk  in  1  sole clock; all logic on its rising edge.
REQ-007 aresetn  in  1  asynchronous, active-low reset.
REQ-008 aw_rd_empty  in  1  AW FIFO empty.
REQ-009 aw_rd_en  out  1  AW FIFO pop.
REQ-010 aw_rd_data  in  A_W  AW FIFO head (awaddr); valid while aw_rd_empty=0.
REQ-011 w_rd_empty  in  1  W FIFO empty.
REQ-012 w_rd_en  out  1  W FIFO pop.
REQ-013 w_rd_data  in  D_W+D_W/8  W FIFO head {wstrb, wdata}; valid while w_rd_empty=0.
REQ-014 b_wr_full  in  1  B FIFO full.
REQ-015 b_wr_en  out  1  B FIFO push.
REQ-016 b_wr_data  out  2  bresp pushed into the B FIFO.
REQ-017 reg_wr_en  out  1  register-port write request, held until accepted.
REQ-018 reg_addr  out  A_W  word-aligned write address.
REQ-019 reg_wdata  out  D_W  write data.
REQ-020 reg_wstrb  out  D_W/8  byte strobes.
REQ-021 reg_ack  in  1  register port accepts the write this cycle.
REQ-022 reg_err  in  1  qualifies reg_ack: write accepted with slave error.
REQ-023 busy  out  1  high whenever state is not IDLE.

Function
REQ-024 The state machine SHALL have states IDLE, WRITE, RESP.
REQ-025 IDLE: when aw_rd_empty=0 and w_rd_empty=0, the block SHALL assert aw_rd_en and w_rd_en together for exactly one cycle and capture both heads into registers.
REQ-026 An AW pop without a W pop, or a W pop without an AW pop, SHALL never occur.
REQ-027 On the capture edge, an address inside [BASE, BASE+SIZE) SHALL go to WRITE; otherwise the block SHALL go to RESP with bresp=2'b11 (DECERR) and SHALL NOT assert reg_wr_en.
REQ-028 reg_addr SHALL equal the captured address with its low log2(D_W/8) bits forced to zero.
REQ-029 WRITE: reg_wr_en=1 with reg_addr, reg_wdata and reg_wstrb stable until reg_ack=1 or timeout.
REQ-030 On reg_ack=1, bresp SHALL be 2'b10 (SLVERR) if reg_err=1, else 2'b00 (OKAY); the next state is RESP and reg_wr_en drops on the following cycle.
REQ-031 A 16-bit wait counter SHALL clear on entry to WRITE and increment each WRITE cycle without reg_ack; when it reaches TIMEOUT, the block SHALL go to RESP with bresp=2'b10 and drop reg_wr_en.
REQ-032 If reg_ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL take priority.
REQ-033 RESP: b_wr_en=1 with b_wr_data=bresp only while b_wr_full=0; the push cycle returns to IDLE; a full B FIFO SHALL stall in RESP indefinitely.
REQ-034 No new pop SHALL occur in the RESP push cycle; minimum throughput is one write per 3 cycles.
REQ-035 Latency: pop at cycle N, reg_wr_en at N+1, ack at N+1 gives b_wr_en at N+2 with B not full.
REQ-036 reg_ack and reg_err outside WRITE SHALL be ignored.
REQ-037 aw_rd_en, w_rd_en, b_wr_en and reg_wr_en SHALL be registered outputs.

Reset
REQ-038 While aresetn=0: state=IDLE, counter=0, and all outputs 0 (aw_rd_en, w_rd_en, b_wr_en, b_wr_data, reg_wr_en, reg_addr, reg_wdata, reg_wstrb, busy).
REQ-039 Reset asserted mid-transaction SHALL abandon it: no B push, and already-popped FIFO entries are not restored.
REQ-040 After release, operation SHALL resume from IDLE on the first rising edge with aresetn=1.

Verification
REQ-041 Single write: AW 0x0000_0010, W {0xF, 0xDEADBEEF}, reg_ack on first WRITE cycle -> one pop pulse; reg_addr=0x10, reg_wdata=0xDEADBEEF; b_wr_data=2'b00 two cycles after the pop.
REQ-042 Decode miss: AW 0x0000_2000 with SIZE=4096 -> reg_wr_en never asserted; B push with 2'b11.
REQ-043 Timeout: TIMEOUT=4, reg_ack held 0 -> reg_wr_en high for exactly 4 cycles; B push with 2'b10.
REQ-044 Backpressure and ordering: b_wr_full=1 for 10 cycles in RESP -> busy stays 1 and no pop occurs; then 3 queued writes complete in order with no dropped or extra pops.
REQ-045 Unbalanced FIFOs and reset: AW non-empty with W empty for 20 cycles -> no pops; aresetn pulsed low during WRITE -> all outputs 0 at once and no B push.
